// File: rtl/select_pkg.sv
// Shared types and limits for the select debouncer and related input-conditioning blocks.
package select_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } state_t;

  localparam int unsigned DEBOUNCE_MIN = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic stage1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/select_debouncer.sv
// Synchronises and debounces a raw switch into the mux select S, with registered edge pulses.
// Define SELECT_TOGGLE_EN to make each debounced press toggle S instead of following the level.
module select_debouncer
  import select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_RAW,
  output logic S,
  output logic S_RISE,
  output logic S_FALL,
  output logic BUSY
);

  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_cfg
    $error("select_debouncer: DEBOUNCE_CYCLES below DEBOUNCE_MIN");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sw_sync;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             rise_done, fall_done;
  logic             s_next;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (SW_RAW),
    .q   (sw_sync)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rise_done  = 1'b0;
    fall_done  = 1'b0;
    case (state)
      ST_LOW: begin
        if (sw_sync) begin
          cnt_next   = CNT_ONE;
          state_next = ST_RISE_WAIT;
        end
      end
      ST_RISE_WAIT: begin
        if (!sw_sync) begin
          cnt_next   = '0;
          state_next = ST_LOW;
        end else if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          rise_done  = 1'b1;
          state_next = ST_HIGH;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sw_sync) begin
          cnt_next   = CNT_ONE;
          state_next = ST_FALL_WAIT;
        end
      end
      ST_FALL_WAIT: begin
        if (sw_sync) begin
          cnt_next   = '0;
          state_next = ST_HIGH;
        end else if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          fall_done  = 1'b1;
          state_next = ST_LOW;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_LOW;
      end
    endcase
  end

  // S is its own flop so toggle mode can diverge from the debounced level held in the state.
`ifdef SELECT_TOGGLE_EN
  always_comb s_next = S ^ rise_done;
`else
  always_comb s_next = rise_done ? 1'b1 : (fall_done ? 1'b0 : S);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_LOW;
      cnt    <= '0;
      S      <= 1'b0;
      S_RISE <= 1'b0;
      S_FALL <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      S      <= s_next;
      S_RISE <= s_next & ~S;
      S_FALL <= ~s_next & S;
      BUSY   <= (cnt_next != '0);
    end
  end

endmodule

// File: tb/tb_select_debouncer.sv
// Self-checking bench for select_debouncer (DEBOUNCE_CYCLES=4); honours SELECT_TOGGLE_EN.
module tb_select_debouncer;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst;
  logic sw_raw;
  logic s, s_rise, s_fall, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  select_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK    (clk),
    .RST    (rst),
    .SW_RAW (sw_raw),
    .S      (s),
    .S_RISE (s_rise),
    .S_FALL (s_fall),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the input reaches the qualifier two edges late; the debounced level flips once
  // DC consecutive samples disagree with it, and any agreeing sample restarts the count.
  bit m_hist[2];
  int m_run;
  bit m_level, m_s, m_rise, m_fall, m_busy;

  always @(posedge clk) begin
    bit smp, prev;
    if (rst) begin
      m_hist = '{1'b0, 1'b0};
      m_run  = 0;
      m_level = 0; m_s = 0; m_rise = 0; m_fall = 0; m_busy = 0;
    end else begin
      smp = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = sw_raw;
      m_run = (smp != m_level) ? m_run + 1 : 0;
      prev = m_s;
      if (m_run == DC) begin
        m_run   = 0;
        m_level = ~m_level;
`ifdef SELECT_TOGGLE_EN
        if (m_level) m_s = ~m_s;
`else
        m_s = m_level;
`endif
      end
      m_rise = m_s & ~prev;
      m_fall = ~m_s & prev;
      m_busy = (m_run != 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_S", s, m_s);
      chk("model_S_RISE", s_rise, m_rise);
      chk("model_S_FALL", s_fall, m_fall);
      chk("model_BUSY", busy, m_busy);
    end
  end

  // Drive a new level at a negedge; the next posedge is edge 0. Checks after edges 0..8.
  task automatic settle(input logic val, input logic s_before, input logic s_after,
                        input logic qualifies);
    sw_raw = val;
    for (int e = 0; e <= 8; e++) begin
      @(negedge clk);
      chk("settle_S", s, (e < DC + 1) ? s_before : s_after);
      chk("settle_S_RISE", s_rise, (e == DC + 1) && s_after && !s_before);
      chk("settle_S_FALL", s_fall, (e == DC + 1) && !s_after && s_before);
      chk("settle_BUSY", busy, qualifies && (e >= 2) && (e <= DC));
    end
  endtask

  initial begin
    logic pre;
    rst = 1'b1;
    sw_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_en = 1;
      chk("reset_S", s, 1'b0);
      chk("reset_S_RISE", s_rise, 1'b0);
      chk("reset_S_FALL", s_fall, 1'b0);
      chk("reset_BUSY", busy, 1'b0);
    end

    // Release with the switch already high: full-latency rise.
    rst = 1'b0;
    settle(1'b1, 1'b0, 1'b1, 1'b1);

    // Clean fall.
`ifdef SELECT_TOGGLE_EN
    settle(1'b0, 1'b1, 1'b1, 1'b1);
`else
    settle(1'b0, 1'b1, 1'b0, 1'b1);
`endif

    // Bounce 1,0,1,0 every 2 cycles then settle high.
    pre = s;
    for (int i = 0; i < 4; i++) begin
      sw_raw = (i % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        chk("bounce_S_hold", s, pre);
      end
    end
    settle(1'b1, pre, ~pre, 1'b1);

    // Reset when the fall counter has reached 2.
    sw_raw = 1'b0;
    repeat (4) @(negedge clk);
    chk("midq_BUSY_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midq_S", s, 1'b0);
    chk("midq_S_RISE", s_rise, 1'b0);
    chk("midq_S_FALL", s_fall, 1'b0);
    chk("midq_BUSY", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    settle(1'b1, 1'b0, 1'b1, 1'b1);

    // Press/release cycles.
`ifdef SELECT_TOGGLE_EN
    settle(1'b0, 1'b1, 1'b1, 1'b1);
    settle(1'b1, 1'b1, 1'b0, 1'b1);
    settle(1'b0, 1'b0, 1'b0, 1'b1);
`else
    settle(1'b0, 1'b1, 1'b0, 1'b1);
    settle(1'b1, 1'b0, 1'b1, 1'b1);
    settle(1'b0, 1'b1, 1'b0, 1'b1);
`endif
    settle(1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch one sample short of acceptance never reaches S.
    pre = s;
    sw_raw = 1'b1;
    repeat (DC - 1) @(negedge clk);
    sw_raw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("glitch_S_hold", s, pre);
    end

    // Pulse of exactly DC cycles is accepted, then released.
    sw_raw = 1'b1;
    repeat (DC) @(negedge clk);
    sw_raw = 1'b0;
    repeat (12) @(negedge clk);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
